// File: rtl/usb_sched_pkg.sv
// usb_sched_pkg: shared state encoding and widths for the USB read scheduler
package usb_sched_pkg;
    localparam int USB_NCH = 8;
    localparam int BTYPE_W = 4;
    localparam int IDX_W = 4;
    typedef enum logic [2:0] {IDLE, SEL, REQ, REL, NEXT, DATA, DONE} state_e;
endpackage

// File: rtl/sched_tmo.sv
// sched_tmo: clearable up-counter that flags when it reaches the loaded limit
module sched_tmo #(
    parameter int TW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] lim,
    output logic          expired
);
    logic [TW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + TW'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expired = cnt_q == lim;
endmodule

// File: rtl/usb_read_sched.sv
// usb_read_sched: sequences one read scan over the USB links then data_make; SCHED_RR_EN rotates the start channel
module usb_read_sched
    import usb_sched_pkg::*;
#(
    parameter int NCH     = USB_NCH,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fs,
    output logic                     fd,
    input  logic [0:NCH-1]           dev_en,
    input  logic [BTYPE_W-1:0]       btype,
    output logic [0:NCH-1]           fs_usb_read,
    input  logic [0:NCH-1]           fd_usb_read,
    output logic [0:BTYPE_W*NCH-1]   read_usb_btype,
    output logic                     fs_data,
    input  logic                     fd_data,
    output logic [IDX_W-1:0]         data_idx,
    output logic [0:NCH-1]           tout_mask,
    output logic                     busy
);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
    state_e state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc, last, start;
    logic [0:NCH-1] en_q, en_d, tout_q, tout_d, fs_usb_q, fs_usb_d;
    logic [BTYPE_W-1:0] bt_q, bt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic fs_data_q, fs_data_d, fd_q, fd_d;
    logic tmo_clr, tmo_en, tmo_exp;

    sched_tmo #(.TW(TW)) u_tmo (
        .clk(clk), .rst(rst), .clr(tmo_clr), .en(tmo_en),
        .lim(TW'(TIMEOUT - 1)), .expired(tmo_exp)
    );

`ifdef SCHED_RR_EN
    logic [PW-1:0] start_q, start_d;
    assign start_d = (state_q == DATA && state_d == DONE) ?
                     (start_q == PW'(NCH - 1) ? '0 : start_q + PW'(1)) : start_q;
    always_ff @(posedge clk) start_q <= rst ? '0 : start_d;
    assign start = start_q;
`else
    assign start = '0;
`endif

    assign ptr_inc = ptr_q == PW'(NCH - 1) ? '0 : ptr_q + PW'(1);
    assign last    = start == '0 ? PW'(NCH - 1) : start - PW'(1);
    assign tmo_en  = state_q == REQ || state_q == REL;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        en_d      = en_q;
        bt_d      = bt_q;
        tout_d    = tout_q;
        idx_d     = idx_q;
        fs_usb_d  = '0;
        fs_data_d = fs_data_q;
        fd_d      = fd_q;
        tmo_clr   = 1'b0;
        case (state_q)
            IDLE: if (fs) begin
                en_d    = dev_en;
                bt_d    = btype;
                tout_d  = '0;
                ptr_d   = start;
                state_d = SEL;
            end
            SEL: if (en_q[ptr_q]) begin
                state_d         = REQ;
                tmo_clr         = 1'b1;
                fs_usb_d[ptr_q] = 1'b1;
            end else if (ptr_q == last) begin
                state_d   = DATA;
                fs_data_d = 1'b1;
            end else begin
                ptr_d = ptr_inc;
            end
            REQ: if (fd_usb_read[ptr_q]) begin
                state_d = REL;
                tmo_clr = 1'b1;
            end else if (tmo_exp) begin
                tout_d[ptr_q] = 1'b1;
                state_d       = NEXT;
            end else begin
                fs_usb_d = fs_usb_q;
            end
            // a responder still holding fd at expiry is flagged as timed out
            REL: if (!fd_usb_read[ptr_q] || tmo_exp) begin
                tout_d[ptr_q] = fd_usb_read[ptr_q];
                state_d       = NEXT;
            end
            NEXT: if (ptr_q == last) begin
                state_d   = DATA;
                fs_data_d = 1'b1;
            end else begin
                ptr_d   = ptr_inc;
                state_d = SEL;
            end
            DATA: if (fs_data_q) begin
                fs_data_d = !fd_data;
            end else if (!fd_data) begin
                idx_d   = idx_q + IDX_W'(1);
                fd_d    = 1'b1;
                state_d = DONE;
            end
            DONE: if (!fs) begin
                fd_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            en_q      <= '0;
            bt_q      <= '0;
            tout_q    <= '0;
            idx_q     <= '0;
            fs_usb_q  <= '0;
            fs_data_q <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            en_q      <= en_d;
            bt_q      <= bt_d;
            tout_q    <= tout_d;
            idx_q     <= idx_d;
            fs_usb_q  <= fs_usb_d;
            fs_data_q <= fs_data_d;
            fd_q      <= fd_d;
        end
    end

    assign fd             = fd_q;
    assign fs_usb_read    = fs_usb_q;
    assign read_usb_btype = {NCH{bt_q}};
    assign fs_data        = fs_data_q;
    assign data_idx       = idx_q;
    assign tout_mask      = tout_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_usb_read_sched.sv
// tb_usb_read_sched: randomized scans checked against a scan-level model of order, timeouts, index and btype
module tb_usb_read_sched;
    localparam int TO = 16;
    logic clk = 0, rst = 1, fs = 0, fd, fs_data, fd_data = 0, busy;
    logic [0:7] dev_en = '0, fs_usb_read, fd_usb_read = '0, tout_mask;
    logic [3:0] btype = '0, data_idx;
    logic [0:31] read_usb_btype;
    int checks = 0, errors = 0;
    int mode[8], dly[8], rcnt[8], dcnt = 0;
    int exp_q[$];
    logic [0:7] exp_tout = '0;
    logic [0:31] exp_bt = '0;
    int exp_idx = 0, start = 0, data_rises = 0;
    bit chk_on = 0;

    usb_read_sched #(.NCH(8), .TIMEOUT(TO), .TW(5)) dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .dev_en(dev_en), .btype(btype),
        .fs_usb_read(fs_usb_read), .fd_usb_read(fd_usb_read),
        .read_usb_btype(read_usb_btype), .fs_data(fs_data), .fd_data(fd_data),
        .data_idx(data_idx), .tout_mask(tout_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // USB and data_make responders; mode 0 answers after dly, 1 is mute, 2 never releases fd
    initial begin
        foreach (rcnt[i]) rcnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                if (fs_usb_read[c] && !fd_usb_read[c]) begin
                    rcnt[c]++;
                    if (mode[c] != 1 && rcnt[c] >= dly[c]) fd_usb_read[c] = 1'b1;
                end else if (!fs_usb_read[c]) begin
                    if (mode[c] != 2) fd_usb_read[c] = 1'b0;
                    rcnt[c] = 0;
                end
            end
            if (fs_data && !fd_data) begin
                dcnt++;
                if (dcnt >= 2) fd_data = 1'b1;
            end else if (!fs_data) begin
                fd_data = 1'b0;
                dcnt = 0;
            end
        end
    end

    initial begin
        logic [0:7] pf;
        logic pfd, pfsd;
        int hold[8];
        pf = '0; pfd = 0; pfsd = 0;
        foreach (hold[i]) hold[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_on) begin
                check("one_request", $countones({fs_usb_read, fs_data}) <= 1, 1);
                check("btype", read_usb_btype, exp_bt);
                if (fd && !pfd) begin
                    exp_idx = (exp_idx + 1) % 16;
                    check("tout_mask", tout_mask, exp_tout);
                    check("order_left", exp_q.size(), 0);
                    check("fs_data_pulses", data_rises, 1);
                    data_rises = 0;
                end
                check("data_idx", data_idx, exp_idx);
                if (|fs_usb_read || fs_data || fd) check("busy", busy, 1);
                for (int c = 0; c < 8; c++) begin
                    if (fs_usb_read[c] && !pf[c]) begin
                        check("order", c, exp_q.size() > 0 ? exp_q[0] : 99);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        hold[c] = 0;
                    end
                    if (fs_usb_read[c]) hold[c]++;
                    if (!fs_usb_read[c] && pf[c] && mode[c] == 1) check("mute_hold", hold[c], TO);
                end
                if (fs_data && !pfsd) data_rises++;
            end
            pf = fs_usb_read; pfd = fd; pfsd = fs_data;
        end
    end

    task automatic scan(input logic [0:7] en, input logic [3:0] bt, input bit mid);
        int n;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            int c = (start + k) % 8;
            if (en[c]) exp_q.push_back(c);
        end
        exp_tout = '0;
        for (int c = 0; c < 8; c++) if (en[c] && mode[c] != 0) exp_tout[c] = 1'b1;
        @(negedge clk);
        dev_en = en; btype = bt; fs = 1'b1; exp_bt = {8{bt}};
        if (mid) begin
            @(negedge clk);
            btype = 4'h3; dev_en = ~en;
            repeat (4) @(negedge clk);
            check("btype_mid", read_usb_btype, 32'hAAAA_AAAA);
        end
        n = 0;
        while (!fd && n < 2000) begin @(negedge clk); n++; end
        check("fd_rise", fd, 1);
        fs = 1'b0;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        check("idle", busy, 0);
`ifdef SCHED_RR_EN
        start = (start + 1) % 8;
`endif
    endtask

    initial begin
        int n;
        foreach (mode[i]) begin mode[i] = 0; dly[i] = 3; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_outs", {fd, fs_usb_read, fs_data, data_idx, tout_mask, busy}, 0);
        check("rst_btype", read_usb_btype, 0);
        chk_on = 1;

        scan(8'hFF, 4'h5, 0);
        check("s1_idx", data_idx, 1);
        check("s1_tout", tout_mask, 0);

        mode[7] = 1;
        scan(8'b0010_0001, 4'h2, 0);
        check("s2_tout", tout_mask, 8'b0000_0001);
        mode[7] = 0;

        scan(8'h00, 4'h1, 0);
        check("s3_idx", data_idx, 3);

        scan(8'hFF, 4'hA, 1);
        check("s4_btype_after", read_usb_btype, 32'hAAAA_AAAA);

        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 8; c++) begin
                mode[c] = ($urandom % 6 == 0) ? 1 : ($urandom % 8 == 0) ? 2 : 0;
                dly[c] = 1 + $urandom % 5;
            end
            scan(8'($urandom), 4'($urandom), 0);
        end
        check("wrap_idx", data_idx, 5);

        foreach (mode[i]) begin mode[i] = 0; dly[i] = 2; end
        mode[4] = 1;
        repeat (2) @(negedge clk);
        exp_q.delete(); exp_q.push_back(4);
        dev_en = 8'b0000_1000; btype = 4'h9; fs = 1'b1; exp_bt = 32'h9999_9999;
        n = 0;
        while (!fs_usb_read[4] && n < 100) begin @(negedge clk); n++; end
        check("req_ch4", fs_usb_read, 8'b0000_1000);
        repeat (3) @(negedge clk);
        chk_on = 0;
        rst = 1'b1; fs = 1'b0;
        @(posedge clk); #1;
        check("midrst_outs", {fd, fs_usb_read, fs_data, data_idx, tout_mask, busy}, 0);
        check("midrst_btype", read_usb_btype, 0);
        @(negedge clk);
        rst = 1'b0;
        mode[4] = 0;
        exp_idx = 0; start = 0; exp_bt = '0; data_rises = 0; exp_q.delete();
        @(negedge clk);
        chk_on = 1;
        scan(8'hFF, 4'h6, 0);
        check("post_rst_idx", data_idx, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
